regfile_wb_arbiter: RTL
=======================

# regfile_wb_arbiter

Write-back arbiter sharing the register file's single write port (WE3/A3/WD3) among three producers: ALU write-back, memory-load write-back and a debug/host port. Each producer has a one-entry holding buffer with valid/ready handshake; a fixed-priority plus round-robin arbiter drains one buffer per cycle into registered write-port outputs. The block also flags read-after-write hazards for the two read addresses while a write is still buffered.

## Interface
- DATA_W, 32, write data width
- ADDR_W, 5, register address width (32 registers, r0 hard-wired zero)
- clk  in  1  clock; all state updates on posedge
- reset  in  1  reset, synchronous, active-high
- alu_valid / mem_valid / dbg_valid  in  1 each  producer has a write to offer
- alu_ready / mem_ready / dbg_ready  out  1 each  producer's write accepted this edge if valid
- alu_addr / mem_addr / dbg_addr  in  ADDR_W each  destination register
- alu_data / mem_data / dbg_data  in  DATA_W each  write value
- we3  out  1  register-file write enable (registered)
- a3  out  ADDR_W  register-file write address (registered)
- wd3  out  DATA_W  register-file write data (registered)
- ra1, ra2  in  ADDR_W  current register-file read addresses A1/A2
- hz1, hz2  out  1  hazard: ra1/ra2 targets a buffered, not-yet-issued write

## Operation
- Buffers: one entry per producer {full, addr, data}. Accept when valid && ready; a write to address 0 is handshaken but discarded (buffer stays empty, no write slot used).
- ready_x = !full_x || grant_x (a buffer drained this cycle can refill the same edge). Grant depends only on buffer state, never on *_valid; no combinational loop.
- Arbitration, one grant per cycle among full buffers:
  - dbg full -> grant dbg.
  - else only one of alu/mem full -> grant it.
  - else both full, same addr -> grant older entry (age flag; simultaneous accept: alu older).
  - else both full, different addr -> round-robin, alternating from last alu/mem grant; pointer resets to "alu next".
- Issue: on grant, register we3=1, a3/wd3 = granted entry; clear granted full unless refilled same edge. No grant -> we3=0, a3/wd3 hold previous values.
- Hazard: hz1 = (ra1 != 0) && (ra1 matches addr of any full buffer); same for hz2. Combinational. The issued write (we3 register) is not a hazard; the file writes it on the following negedge, before end-of-cycle sampling.
- Reset: all buffers empty, age flag and RR pointer cleared, we3=0, a3=0, wd3=0; all ready=1; hz1=hz2=0. Reset mid-operation discards buffered writes; nothing issued in the reset cycle.

## Timing
- Latency: accept at posedge N -> we3/a3/wd3 valid after posedge N+1 (if granted) -> register file updates on negedge in cycle N+1.
- Throughput: one write per cycle total; each producer sustains one write per cycle when uncontended.
- Worst-case wait with dbg idle: alu/mem at most 1 extra cycle (RR). Continuous dbg traffic may starve alu/mem by design.
- Outputs we3/a3/wd3 change only on posedge, stable across the register-file negedge write.

## Test plan
- Reset: assert reset 2 cycles with all producers valid -> we3=0, a3=0, wd3=0, ready=1, hz=0, no write issued; r5 unchanged after release.
- Single ALU write: alu addr=5 data=0xDEADBEEF for one cycle at edge N -> we3=1, a3=5, wd3=0xDEADBEEF after edge N+1, we3=0 after N+2; reading r5 returns 0xDEADBEEF.
- Contention: alu(3,0x11), mem(4,0x22), dbg(7,0x33) accepted same edge -> issue order dbg r7, alu r3, mem r4 on three consecutive cycles; second alu offer waits (alu_ready=0) until its buffer drains.
- Same-address ordering: mem(9,0xAA) accepted edge N, alu(9,0xBB) edge N+1 while dbg busy -> mem issued before alu; final r9=0xBB.
- r0 and hazard: alu(0,0xFF) -> handshaken, we3 stays 0; buffered mem(12,...) with ra1=12, ra2=0 -> hz1=1, hz2=0 until the cycle it issues, then hz1=0.
- Back-to-back streaming: alu valid every cycle addrs 1..8, mem idle -> alu_ready constantly 1, eight writes on eight consecutive cycles; reset at 4th issue -> remaining writes dropped, we3=0 next cycle.

Source files
------------

// File: rtl/regfile_wb_if.sv
// Write-back bus shared between the three producers, the register-file
// write port and the read-address hazard lookup.
interface regfile_wb_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
);
    logic              alu_valid;
    logic              alu_ready;
    logic [ADDR_W-1:0] alu_addr;
    logic [DATA_W-1:0] alu_data;

    logic              mem_valid;
    logic              mem_ready;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_data;

    logic              dbg_valid;
    logic              dbg_ready;
    logic [ADDR_W-1:0] dbg_addr;
    logic [DATA_W-1:0] dbg_data;

    logic              we3;
    logic [ADDR_W-1:0] a3;
    logic [DATA_W-1:0] wd3;

    logic [ADDR_W-1:0] ra1;
    logic [ADDR_W-1:0] ra2;
    logic              hz1;
    logic              hz2;

    modport slave (
        input  alu_valid, alu_addr, alu_data,
        input  mem_valid, mem_addr, mem_data,
        input  dbg_valid, dbg_addr, dbg_data,
        input  ra1, ra2,
        output alu_ready, mem_ready, dbg_ready,
        output we3, a3, wd3,
        output hz1, hz2
    );

    modport master (
        output alu_valid, alu_addr, alu_data,
        output mem_valid, mem_addr, mem_data,
        output dbg_valid, dbg_addr, dbg_data,
        output ra1, ra2,
        input  alu_ready, mem_ready, dbg_ready,
        input  we3, a3, wd3,
        input  hz1, hz2
    );
endinterface

// File: rtl/regfile_wb_arbiter.sv
// Shares the register file's single write port among ALU, load and debug
// producers through one-entry buffers, and flags RAW hazards on buffered writes.
module regfile_wb_arbiter #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
) (
    input logic         clk,
    input logic         reset,
    regfile_wb_if.slave wb
);
    localparam int ALU = 0;
    localparam int MEM = 1;
    localparam int DBG = 2;

    logic [2:0]        full_q, full_d;
    logic [ADDR_W-1:0] addr_q [3];
    logic [ADDR_W-1:0] addr_d [3];
    logic [DATA_W-1:0] data_q [3];
    logic [DATA_W-1:0] data_d [3];
    logic              mem_older_q, mem_older_d;
    logic              rr_mem_q, rr_mem_d;
    logic              we3_q, we3_d;
    logic [ADDR_W-1:0] a3_q, a3_d;
    logic [DATA_W-1:0] wd3_q, wd3_d;

    logic [2:0]        valid;
    logic [2:0]        ready;
    logic [2:0]        grant;
    logic [2:0]        load;
    logic [ADDR_W-1:0] in_addr [3];
    logic [DATA_W-1:0] in_data [3];
    logic              hz1_any, hz2_any;

    assign valid      = {wb.dbg_valid, wb.mem_valid, wb.alu_valid};
    assign in_addr[ALU] = wb.alu_addr;
    assign in_addr[MEM] = wb.mem_addr;
    assign in_addr[DBG] = wb.dbg_addr;
    assign in_data[ALU] = wb.alu_data;
    assign in_data[MEM] = wb.mem_data;
    assign in_data[DBG] = wb.dbg_data;

    // Grant looks only at buffer state so ready never depends on valid.
    always_comb begin
        grant = '0;
        if (full_q[DBG]) begin
            grant[DBG] = 1'b1;
        end else if (full_q[ALU] && full_q[MEM]) begin
            if (addr_q[ALU] == addr_q[MEM]) begin
                if (mem_older_q) grant[MEM] = 1'b1;
                else             grant[ALU] = 1'b1;
            end else if (rr_mem_q) begin
                grant[MEM] = 1'b1;
            end else begin
                grant[ALU] = 1'b1;
            end
        end else if (full_q[ALU]) begin
            grant[ALU] = 1'b1;
        end else if (full_q[MEM]) begin
            grant[MEM] = 1'b1;
        end
    end

    assign ready = reset ? 3'b111 : (~full_q | grant);

    always_comb begin
        full_d      = full_q;
        load        = '0;
        mem_older_d = mem_older_q;
        rr_mem_d    = rr_mem_q;
        we3_d       = |grant;
        a3_d        = a3_q;
        wd3_d       = wd3_q;
        for (int i = 0; i < 3; i++) begin
            addr_d[i] = addr_q[i];
            data_d[i] = data_q[i];
            // Writes to r0 complete the handshake but never occupy the buffer.
            load[i]   = valid[i] && ready[i] && (in_addr[i] != '0);
            full_d[i] = load[i] || (full_q[i] && !grant[i]);
            if (load[i]) begin
                addr_d[i] = in_addr[i];
                data_d[i] = in_data[i];
            end
            if (grant[i]) begin
                a3_d  = addr_q[i];
                wd3_d = data_q[i];
            end
        end

        // A fresh mem entry is always the younger one; simultaneous loads make alu older.
        if (load[MEM])      mem_older_d = 1'b0;
        else if (load[ALU]) mem_older_d = 1'b1;

        if (grant[ALU])      rr_mem_d = 1'b1;
        else if (grant[MEM]) rr_mem_d = 1'b0;

        if (reset) begin
            full_d      = '0;
            mem_older_d = 1'b0;
            rr_mem_d    = 1'b0;
            we3_d       = 1'b0;
            a3_d        = '0;
            wd3_d       = '0;
        end
    end

    always_ff @(posedge clk) begin
        full_q      <= full_d;
        addr_q      <= addr_d;
        data_q      <= data_d;
        mem_older_q <= mem_older_d;
        rr_mem_q    <= rr_mem_d;
        we3_q       <= we3_d;
        a3_q        <= a3_d;
        wd3_q       <= wd3_d;
    end

    // The issued write lands in the file before sampling, so only buffers count.
    always_comb begin
        hz1_any = 1'b0;
        hz2_any = 1'b0;
        for (int i = 0; i < 3; i++) begin
            if (full_q[i] && (addr_q[i] == wb.ra1)) hz1_any = 1'b1;
            if (full_q[i] && (addr_q[i] == wb.ra2)) hz2_any = 1'b1;
        end
    end

    assign wb.hz1 = !reset && (wb.ra1 != '0) && hz1_any;
    assign wb.hz2 = !reset && (wb.ra2 != '0) && hz2_any;

    assign wb.alu_ready = ready[ALU];
    assign wb.mem_ready = ready[MEM];
    assign wb.dbg_ready = ready[DBG];
    assign wb.we3       = we3_q;
    assign wb.a3        = a3_q;
    assign wb.wd3       = wd3_q;
endmodule
